// File: rtl/mult_seq_if.sv
// mult_seq_if: request/result handshake plus the shared-adder port bundle of
// the MULT/MULTU sequencer.
//   start, is_signed, a, b : request from the core (sampled with start in IDLE)
//   busy, done, hi, lo     : sequencer status and 64-bit product
//   add_a, add_b, add_cin  : operands driven into the shared 32-bit adder
//   add_sum, add_cout      : combinational result of the shared adder
// master = requester side that also hosts the adder, slave = the sequencer.
interface mult_seq_if;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, hi, lo,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, hi, lo,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout
    );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: multi-cycle shift-and-add sequencer for MULT/MULTU. It owns no
// adder; every arithmetic step (absolute value, accumulation, final negation)
// goes through an external 32-bit adder reached via the bus adder ports.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mult_seq_if.slave (request, status/result, shared adder ports)
// Latency from the sampling edge to done: 33 edges (MULTU), 37 edges (MULT).
module mult_seq (
    input  logic        clk,
    input  logic        rst,
    mult_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABS_A  = 3'd1,
        ABS_B  = 3'd2,
        ITER   = 3'd3,
        NEG_LO = 3'd4,
        NEG_HI = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t      state_r, state_n;
    logic [31:0] mcand_r, mcand_n;
    logic [31:0] ph_r, ph_n;
    logic [31:0] pl_r, pl_n;
    logic [5:0]  cnt_r, cnt_n;
    logic        neg_r, neg_n;
    logic        sa_r, sa_n;
    logic        sb_r, sb_n;
    logic        c_r, c_n;
    logic        sgn_r, sgn_n;
    logic [31:0] hi_r, lo_r;
    logic        busy_r, done_r;

    logic [31:0] add_a_s, add_b_s;
    logic        add_cin_s;

    // Adder operand selection: depends only on state and registers so the
    // external adder path never loops back into its own operands.
    always_comb begin
        add_a_s   = 32'd0;
        add_b_s   = 32'd0;
        add_cin_s = 1'b0;
        case (state_r)
            ABS_A: begin
                // ~x + 1 negates; sa = 0 passes mcand through unchanged.
                add_a_s   = sa_r ? ~mcand_r : mcand_r;
                add_cin_s = sa_r;
            end
            ABS_B: begin
                add_a_s   = sb_r ? ~pl_r : pl_r;
                add_cin_s = sb_r;
            end
            ITER: begin
                add_a_s = ph_r;
                add_b_s = pl_r[0] ? mcand_r : 32'd0;
            end
            NEG_LO: begin
                add_a_s   = neg_r ? ~pl_r : pl_r;
                add_cin_s = neg_r;
            end
            NEG_HI: begin
                // Low-word carry ripples into the high word of the negation.
                add_a_s   = neg_r ? ~ph_r : ph_r;
                add_cin_s = neg_r & c_r;
            end
            default: begin
                add_a_s   = 32'd0;
                add_b_s   = 32'd0;
                add_cin_s = 1'b0;
            end
        endcase
    end

    assign bus.add_a   = add_a_s;
    assign bus.add_b   = add_b_s;
    assign bus.add_cin = add_cin_s;

    // Next-state and next-register computation, consuming the adder result.
    always_comb begin
        state_n = state_r;
        mcand_n = mcand_r;
        ph_n    = ph_r;
        pl_n    = pl_r;
        cnt_n   = cnt_r;
        neg_n   = neg_r;
        sa_n    = sa_r;
        sb_n    = sb_r;
        c_n     = c_r;
        sgn_n   = sgn_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    mcand_n = bus.a;
                    pl_n    = bus.b;
                    ph_n    = 32'd0;
                    cnt_n   = 6'd0;
                    sa_n    = bus.is_signed & bus.a[31];
                    sb_n    = bus.is_signed & bus.b[31];
                    neg_n   = (bus.is_signed & bus.a[31]) ^ (bus.is_signed & bus.b[31]);
                    sgn_n   = bus.is_signed;
                    state_n = bus.is_signed ? ABS_A : ITER;
                end else begin
                    state_n = IDLE;
                end
            end
            ABS_A: begin
                mcand_n = bus.add_sum;
                state_n = ABS_B;
            end
            ABS_B: begin
                pl_n    = bus.add_sum;
                state_n = ITER;
            end
            ITER: begin
                // 65-bit {cout, sum, pl} shifted right by one.
                ph_n  = {bus.add_cout, bus.add_sum[31:1]};
                pl_n  = {bus.add_sum[0], pl_r[31:1]};
                cnt_n = cnt_r + 6'd1;
                if (cnt_r == 6'd31) begin
                    state_n = sgn_r ? NEG_LO : DONE;
                end else begin
                    state_n = ITER;
                end
            end
            NEG_LO: begin
                pl_n    = bus.add_sum;
                c_n     = bus.add_cout;
                state_n = NEG_HI;
            end
            NEG_HI: begin
                ph_n    = bus.add_sum;
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; async reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            mcand_r <= 32'd0;
            ph_r    <= 32'd0;
            pl_r    <= 32'd0;
            cnt_r   <= 6'd0;
            neg_r   <= 1'b0;
            sa_r    <= 1'b0;
            sb_r    <= 1'b0;
            c_r     <= 1'b0;
            sgn_r   <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            mcand_r <= mcand_n;
            ph_r    <= ph_n;
            pl_r    <= pl_n;
            cnt_r   <= cnt_n;
            neg_r   <= neg_n;
            sa_r    <= sa_n;
            sb_r    <= sb_n;
            c_r     <= c_n;
            sgn_r   <= sgn_n;
            busy_r  <= (state_n != IDLE);
            done_r  <= (state_n == DONE);
            // Results are published only on the edge entering DONE.
            if (state_n == DONE) begin
                hi_r <= ph_n;
                lo_r <= pl_n;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq; hosts a behavioural 32-bit adder.
module tb_mult_seq;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    mult_seq_if bus ();

    mult_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural stand-in for the shared ripple-carry adder.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and wait (bounded) for done.
    task automatic do_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output int bcnt,
                         output logic [31:0] h, output logic [31:0] l,
                         output logic busy_after, output logic done_after);
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = s; bus.a = av; bus.b = bv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat  = 1;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) bcnt++;
        end
        h = bus.hi;
        l = bus.lo;
        @(posedge clk); #1;
        busy_after = bus.busy;
        done_after = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else passed++;
        total++; if (bus.hi !== 32'd0) $display("FAIL reset_hi got %h exp 0", bus.hi); else passed++;
        total++; if (bus.lo !== 32'd0) $display("FAIL reset_lo got %h exp 0", bus.lo); else passed++;
        total++; if (bus.add_a !== 32'd0) $display("FAIL reset_add_a got %h exp 0", bus.add_a); else passed++;
        total++; if (bus.add_b !== 32'd0) $display("FAIL reset_add_b got %h exp 0", bus.add_b); else passed++;
        total++; if (bus.add_cin !== 1'b0) $display("FAIL reset_add_cin got %b exp 0", bus.add_cin); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic        vs [8];
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] eh [8];
        logic [31:0] el [8];
        int lat, bcnt, elat;
        logic [31:0] h, l;
        logic ba, da;
        // MULTU
        vs[0] = 1'b0; va[0] = 32'd3;          vb[0] = 32'd5;          eh[0] = 32'h00000000; el[0] = 32'h0000000F;
        vs[1] = 1'b0; va[1] = 32'hFFFFFFFF;   vb[1] = 32'hFFFFFFFF;   eh[1] = 32'hFFFFFFFE; el[1] = 32'h00000001;
        vs[2] = 1'b0; va[2] = 32'h80000000;   vb[2] = 32'd2;          eh[2] = 32'h00000001; el[2] = 32'h00000000;
        // MULT
        vs[3] = 1'b1; va[3] = 32'hFFFFFFFD;   vb[3] = 32'd5;          eh[3] = 32'hFFFFFFFF; el[3] = 32'hFFFFFFF1;
        vs[4] = 1'b1; va[4] = 32'hFFFFFFF9;   vb[4] = 32'hFFFFFFFA;   eh[4] = 32'h00000000; el[4] = 32'h0000002A;
        vs[5] = 1'b1; va[5] = 32'h80000000;   vb[5] = 32'h80000000;   eh[5] = 32'h40000000; el[5] = 32'h00000000;
        vs[6] = 1'b1; va[6] = 32'h80000000;   vb[6] = 32'd1;          eh[6] = 32'hFFFFFFFF; el[6] = 32'h80000000;
        vs[7] = 1'b1; va[7] = 32'd0;          vb[7] = 32'hFFFFFFFB;   eh[7] = 32'h00000000; el[7] = 32'h00000000;
        for (int i = 0; i < 8; i++) begin
            do_op(vs[i], va[i], vb[i], lat, bcnt, h, l, ba, da);
            elat = vs[i] ? 37 : 33;
            total++; if (lat !== elat) $display("FAIL vec%0d_latency got %0d exp %0d", i, lat, elat); else passed++;
            total++; if (bcnt !== elat) $display("FAIL vec%0d_busy_cycles got %0d exp %0d", i, bcnt, elat); else passed++;
            total++; if (h !== eh[i]) $display("FAIL vec%0d_hi got %h exp %h", i, h, eh[i]); else passed++;
            total++; if (l !== el[i]) $display("FAIL vec%0d_lo got %h exp %h", i, l, el[i]); else passed++;
            total++; if (ba !== 1'b0) $display("FAIL vec%0d_busy_after got %b exp 0", i, ba); else passed++;
            total++; if (da !== 1'b0) $display("FAIL vec%0d_done_pulse got %b exp 0", i, da); else passed++;
            total++; if (bus.hi !== eh[i]) $display("FAIL vec%0d_hi_held got %h exp %h", i, bus.hi, eh[i]); else passed++;
        end
    endtask

    task automatic test_ignored_start();
        int lat, bcnt;
        logic [31:0] h, l;
        logic ba, da;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd20; bus.b = 32'd20;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 100) begin
            if (lat == 10) begin
                @(negedge clk);
                bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
        end
        total++; if (lat !== 33) $display("FAIL ignore_latency got %0d exp 33", lat); else passed++;
        total++; if (bus.lo !== 32'd400) $display("FAIL ignore_lo got %0d exp 400", bus.lo); else passed++;
        total++; if (bus.hi !== 32'd0) $display("FAIL ignore_hi got %h exp 0", bus.hi); else passed++;
        total++; if (bus.add_a !== 32'd0) $display("FAIL done_add_a got %h exp 0", bus.add_a); else passed++;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL ignore_not_queued got busy %b exp 0", bus.busy); else passed++;
        // Back-to-back: start in the first IDLE cycle after DONE.
        do_op(1'b0, 32'd12, 32'd13, lat, bcnt, h, l, ba, da);
        total++; if (lat !== 33) $display("FAIL b2b_latency got %0d exp 33", lat); else passed++;
        total++; if (l !== 32'd156) $display("FAIL b2b_lo got %0d exp 156", l); else passed++;
        total++; if (h !== 32'd0) $display("FAIL b2b_hi got %h exp 0", h); else passed++;
    endtask

    task automatic test_reset_abort();
        int lat, bcnt;
        logic [31:0] h, l;
        logic ba, da;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.a = 32'd54; bus.b = 32'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.busy); else passed++;
        total++; if (bus.hi !== 32'd0) $display("FAIL abort_hi got %h exp 0", bus.hi); else passed++;
        total++; if (bus.lo !== 32'd0) $display("FAIL abort_lo got %h exp 0", bus.lo); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL abort_done got %b exp 0", bus.done); else passed++;
        @(negedge clk);
        rst = 1'b0;
        do_op(1'b0, 32'd70, 32'd2, lat, bcnt, h, l, ba, da);
        total++; if (lat !== 33) $display("FAIL post_reset_latency got %0d exp 33", lat); else passed++;
        total++; if (l !== 32'd140) $display("FAIL post_reset_lo got %0d exp 140", l); else passed++;
        total++; if (h !== 32'd0) $display("FAIL post_reset_hi got %h exp 0", h); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_vectors();
        test_ignored_start();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
